// File: rtl/tournament_predictor.sv
// Tournament branch predictor: gshare and two-level local components picked by a
// per-PC chooser, tagged direct-mapped BTB, non-speculative training from MEM.
module tournament_predictor #(
  parameter int GHR_LEN   = 8,
  parameter int LHT_IDX   = 6,
  parameter int LHIST_LEN = 6,
  parameter int META_IDX  = 8,
  parameter int BTB_IDX   = 5,
  parameter int CTR_BITS  = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        pred_use_global,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_cond,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] mispredict_count
);

  localparam int GPHT_N = 1 << GHR_LEN;
  localparam int LHT_N  = 1 << LHT_IDX;
  localparam int LPHT_N = 1 << LHIST_LEN;
  localparam int META_N = 1 << META_IDX;
  localparam int BTB_N  = 1 << BTB_IDX;
  localparam int TAG_W  = 30 - BTB_IDX;

  typedef logic [CTR_BITS-1:0] ctr_t;

  typedef struct packed {
    logic             valid;
    logic             is_jump;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  localparam ctr_t CTR_ONE = CTR_BITS'(1);
  localparam ctr_t CTR_MAX = '1;
  localparam ctr_t CTR_WNT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam ctr_t CTR_WG  = {1'b1, {(CTR_BITS-1){1'b0}}};

  function automatic ctr_t sat_step(input ctr_t c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_ONE;
    return (c == '0) ? c : c - CTR_ONE;
  endfunction

  logic [GHR_LEN-1:0]   ghr_q;
  ctr_t                 gpht_q [GPHT_N];
  logic [LHIST_LEN-1:0] lht_q  [LHT_N];
  ctr_t                 lpht_q [LPHT_N];
  ctr_t                 meta_q [META_N];
  btb_entry_t           btb_q  [BTB_N];
  logic [31:0]          mcount_q, mcount_d;

  logic        pred_valid_q, pred_taken_q, pred_use_global_q;
  logic [31:0] pred_target_q;

  // Lookup path (combinational read of current tables)
  logic [GHR_LEN-1:0]   l_gidx;
  logic [LHIST_LEN-1:0] l_lh;
  logic                 l_gpred, l_lpred, l_use_g, l_hit, l_taken;
  btb_entry_t           l_btb;

  assign l_gidx  = lookup_pc[GHR_LEN+1:2] ^ ghr_q;
  assign l_lh    = lht_q[lookup_pc[LHT_IDX+1:2]];
  assign l_gpred = gpht_q[l_gidx][CTR_BITS-1];
  assign l_lpred = lpht_q[l_lh][CTR_BITS-1];
  assign l_use_g = meta_q[lookup_pc[META_IDX+1:2]][CTR_BITS-1];
  assign l_btb   = btb_q[lookup_pc[BTB_IDX+1:2]];
  assign l_hit   = l_btb.valid && (l_btb.tag == lookup_pc[31:BTB_IDX+2]);
  assign l_taken = lookup_valid && l_hit && (l_btb.is_jump || (l_use_g ? l_gpred : l_lpred));

  // Update path: component predictions re-derived from committed state
  logic [GHR_LEN-1:0]   u_gidx;
  logic [LHT_IDX-1:0]   u_lidx;
  logic [LHIST_LEN-1:0] u_lh;
  logic [META_IDX-1:0]  u_midx;
  logic [BTB_IDX-1:0]   u_bidx;
  logic                 u_gpred, u_lpred;

  assign u_gidx  = upd_pc[GHR_LEN+1:2] ^ ghr_q;
  assign u_lidx  = upd_pc[LHT_IDX+1:2];
  assign u_lh    = lht_q[u_lidx];
  assign u_midx  = upd_pc[META_IDX+1:2];
  assign u_bidx  = upd_pc[BTB_IDX+1:2];
  assign u_gpred = gpht_q[u_gidx][CTR_BITS-1];
  assign u_lpred = lpht_q[u_lh][CTR_BITS-1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  always_comb begin
    mcount_d = mcount_q;
    if (upd_valid && upd_mispredict && (mcount_q != 32'hFFFF_FFFF)) mcount_d = mcount_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pred_valid_q      <= 1'b0;
      pred_taken_q      <= 1'b0;
      pred_target_q     <= '0;
      pred_use_global_q <= 1'b0;
    end else if (FLUSH) begin
      pred_valid_q      <= 1'b0;
      pred_taken_q      <= 1'b0;
      pred_target_q     <= '0;
      pred_use_global_q <= 1'b0;
    end else begin
      pred_valid_q      <= lookup_valid;
      pred_taken_q      <= l_taken;
      pred_target_q     <= l_taken ? l_btb.target : 32'd0;
      pred_use_global_q <= lookup_valid && l_use_g;
    end
  end

  // NOTE: the tables carry an async reset because every counter, history and
  // BTB valid bit must come out of reset at a defined value, not just the flops.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ghr_q    <= '0;
      mcount_q <= '0;
      for (int i = 0; i < GPHT_N; i++) gpht_q[i] <= CTR_WNT;
      for (int i = 0; i < LHT_N; i++)  lht_q[i]  <= '0;
      for (int i = 0; i < LPHT_N; i++) lpht_q[i] <= CTR_WNT;
      for (int i = 0; i < META_N; i++) meta_q[i] <= CTR_WG;
      for (int i = 0; i < BTB_N; i++)  btb_q[i]  <= '0;
    end else begin
      mcount_q <= mcount_d;
      if (upd_valid) begin
        if (upd_is_cond) begin
          gpht_q[u_gidx] <= sat_step(gpht_q[u_gidx], upd_taken);
          lpht_q[u_lh]   <= sat_step(lpht_q[u_lh], upd_taken);
          // chooser only learns when the components disagree; up means global
          if (u_gpred != u_lpred) meta_q[u_midx] <= sat_step(meta_q[u_midx], u_gpred == upd_taken);
          ghr_q          <= {ghr_q[GHR_LEN-2:0], upd_taken};
          lht_q[u_lidx]  <= {u_lh[LHIST_LEN-2:0], upd_taken};
        end
        if (upd_taken) begin
          btb_q[u_bidx] <= '{valid: 1'b1, is_jump: ~upd_is_cond,
                             tag: upd_pc[31:BTB_IDX+2], target: upd_target};
        end
      end
    end
  end

  assign pred_valid       = pred_valid_q;
  assign pred_taken       = pred_taken_q;
  assign pred_target      = pred_target_q;
  assign pred_use_global  = pred_use_global_q;
  assign mispredict_count = mcount_q;

endmodule

// File: tb/tb_tournament_predictor.sv
// Directed bench for tournament_predictor with hand-derived expectations for the
// default parameters (GHR 8, local 6/6, chooser 8, BTB 5, 2-bit counters).
module tb_tournament_predictor;

  logic        CLK = 1'b0;
  logic        RESET, FLUSH;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid, pred_taken, pred_use_global;
  logic [31:0] pred_target;
  logic        upd_valid, upd_is_cond, upd_taken, upd_mispredict;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] mispredict_count;

  int vectors = 0;
  int miscompares = 0;

  tournament_predictor dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_use_global(pred_use_global),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_cond(upd_is_cond),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredict(upd_mispredict), .mispredict_count(mispredict_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    tick();
    lookup_valid = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic cond, input logic taken,
                           input logic [31:0] tgt, input logic misp);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_is_cond    = cond;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = misp;
    tick();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic check_pred(input string tag, input logic v, input logic t,
                            input logic [31:0] tgt);
    check({tag, ".valid"},  32'(pred_valid), 32'(v));
    check({tag, ".taken"},  32'(pred_taken), 32'(t));
    check({tag, ".target"}, pred_target, tgt);
  endtask

  initial begin
    RESET = 1'b0; FLUSH = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_is_cond = 1'b0; upd_taken = 1'b0;
    upd_target = '0; upd_mispredict = 1'b0;
    #12;
    check_pred("reset", 1'b0, 1'b0, 32'h0);
    check("reset.use_global", 32'(pred_use_global), 32'd0);
    check("reset.count", mispredict_count, 32'd0);
    RESET = 1'b1;

    // Cold lookup: BTB empty, chooser weakly global
    do_lookup(32'h400);
    check_pred("cold", 1'b1, 1'b0, 32'h0);
    check("cold.use_global", 32'(pred_use_global), 32'd1);
    check("cold.count", mispredict_count, 32'd0);
    tick();
    check("idle.valid", 32'(pred_valid), 32'd0);

    // Jump into BTB, then an alias at the same index with a different tag
    do_update(32'h400, 1'b0, 1'b1, 32'h800, 1'b0);
    do_lookup(32'h400);
    check_pred("jump", 1'b1, 1'b1, 32'h800);
    do_lookup(32'h480);
    check_pred("alias", 1'b1, 1'b0, 32'h0);

    // 12 taken at 0x500: GHR fills to 0xFF, gshare entry 0xBF saturates, chooser moves local
    for (int j = 0; j < 12; j++) do_update(32'h500, 1'b1, 1'b1, 32'h540, 1'b0);
    check("sat.gpht", 32'(dut.gpht_q[8'hBF]), 32'd3);
    do_lookup(32'h500);
    check_pred("cond_t", 1'b1, 1'b1, 32'h540);
    check("cond_t.use_global", 32'(pred_use_global), 32'd0);
    do_lookup(32'h400);
    check_pred("overwritten", 1'b1, 1'b0, 32'h0);

    do_update(32'h500, 1'b1, 1'b0, 32'h540, 1'b0);
    check("sat.dec", 32'(dut.gpht_q[8'hBF]), 32'd2);
    do_update(32'h500, 1'b1, 1'b0, 32'h540, 1'b0);
    check("ghr", 32'(dut.ghr_q), 32'hFC);
    do_lookup(32'h500);
    check_pred("cond_n", 1'b1, 1'b0, 32'h0);

    // Alternating branch at 0x604; chooser: j0 local wins (->1), j1 global wins (->2), j2 agree
    for (int j = 0; j < 32; j++) begin
      do_update(32'h604, 1'b1, (j % 2) == 0, 32'h640, 1'b0);
      if (j == 0) begin
        do_lookup(32'h604);
        check("alt0.use_global", 32'(pred_use_global), 32'd0);
        check("alt0.taken", 32'(pred_taken), 32'd1);
      end else if (j == 1) begin
        do_lookup(32'h604);
        check("alt1.use_global", 32'(pred_use_global), 32'd1);
      end else if (j == 2) begin
        do_lookup(32'h604);
        check("alt2.use_global", 32'(pred_use_global), 32'd1);
      end
    end
    do_lookup(32'h604);
    check_pred("alt_learned", 1'b1, 1'b1, 32'h640);
    check("alt_learned.use_global", 32'(pred_use_global), 32'd0);

    // Lookup and update together: lookup sees the pre-update tables
    lookup_valid = 1'b1; lookup_pc = 32'h604;
    do_update(32'h604, 1'b1, 1'b1, 32'h680, 1'b0);
    lookup_valid = 1'b0;
    check_pred("rbw", 1'b1, 1'b1, 32'h640);
    do_lookup(32'h604);
    check_pred("rbw_after", 1'b1, 1'b0, 32'h0);

    // FLUSH wins over a simultaneous lookup
    do_update(32'h408, 1'b0, 1'b1, 32'h900, 1'b0);
    do_lookup(32'h408);
    check_pred("pre_flush", 1'b1, 1'b1, 32'h900);
    FLUSH = 1'b1;
    do_lookup(32'h408);
    FLUSH = 1'b0;
    check_pred("flush", 1'b0, 1'b0, 32'h0);
    check("flush.use_global", 32'(pred_use_global), 32'd0);
    do_lookup(32'h408);
    check_pred("post_flush", 1'b1, 1'b1, 32'h900);

    // Mispredict statistics and saturation
    for (int j = 0; j < 5; j++) do_update(32'h408, 1'b0, 1'b1, 32'h900, 1'b1);
    check("count5", mispredict_count, 32'd5);
    do_update(32'h408, 1'b0, 1'b1, 32'h900, 1'b0);
    check("count_hold", mispredict_count, 32'd5);
    force dut.mcount_q = 32'hFFFF_FFFD;
    #1;
    release dut.mcount_q;
    do_update(32'h408, 1'b0, 1'b1, 32'h900, 1'b1);
    do_update(32'h408, 1'b0, 1'b1, 32'h900, 1'b1);
    check("count_max", mispredict_count, 32'hFFFF_FFFF);
    do_update(32'h408, 1'b0, 1'b1, 32'h900, 1'b1);
    check("count_sat", mispredict_count, 32'hFFFF_FFFF);

    // Async reset mid-stream with a taken prediction in flight
    do_lookup(32'h408);
    check("pre_reset.taken", 32'(pred_taken), 32'd1);
    lookup_valid = 1'b1; lookup_pc = 32'h408;
    RESET = 1'b0;
    #1;
    check_pred("async_reset", 1'b0, 1'b0, 32'h0);
    check("async_reset.count", mispredict_count, 32'd0);
    #2;
    RESET = 1'b1;
    lookup_valid = 1'b0;
    do_lookup(32'h408);
    check_pred("btb_empty", 1'b1, 1'b0, 32'h0);
    check("btb_empty.use_global", 32'(pred_use_global), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
